// File: rtl/fft_axi_host.sv
// Host-side source/sink for the FFT core AXI bridge: streams a sample buffer out, collects results back.
// Optional FFT_HOST_BURST_CHECK_EN: compare the core's beat indices against the host counters.
module fft_axi_host #(
  parameter int N       = 4,
  parameter int DEPTH_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [11:0]        i_samp_number,
  input  logic               i_ld_we,
  input  logic [DEPTH_W-1:0] i_ld_addr,
  input  logic [31:0]        i_ld_data,
  input  logic [DEPTH_W-1:0] i_rd_addr,
  output logic [32:0]        o_rd_data,
  output logic [31:0]        o_ARDATA,
  output logic               o_ARVALID,
  input  logic               i_ARREADY,
  input  logic [N:0]         i_ARBURST,
  input  logic [32:0]        i_AWDATA,
  input  logic               i_AWVALID,
  output logic               o_AWREADY,
  input  logic [N:0]         i_AWBURST,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error,
  output logic [11:0]        o_sent_cnt,
  output logic [11:0]        o_recv_cnt
);

  localparam int          DEPTH    = 1 << DEPTH_W;
  localparam logic [12:0] MAX_SAMP = 13'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREF,
    S_SEND,
    S_RECV,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0] samp_mem [DEPTH];
  logic [32:0] res_mem  [DEPTH];

  logic [11:0] samp_num_q, samp_num_d;
  logic [11:0] sent_cnt_q, sent_cnt_d;
  logic [11:0] recv_cnt_q, recv_cnt_d;
  logic        error_q, error_d;
  logic [31:0] ardata_q, ardata_d;
  logic [32:0] rd_data_q, rd_data_d;

  logic start_req, start_legal, start_ok, start_bad;
  logic ar_hs, aw_hs, sent_last, recv_last, ld_ok;
  logic [DEPTH_W-1:0] nxt_idx;

`ifndef FFT_HOST_BURST_CHECK_EN
  logic unused_burst;
  assign unused_burst = ^{i_ARBURST, i_AWBURST};
`endif

  assign start_req   = (state_q == S_IDLE) && i_start;
  assign start_legal = ({1'b0, i_samp_number} != 13'd0) &&
                       ({1'b0, i_samp_number} <= MAX_SAMP);
  assign start_ok    = start_req && start_legal;
  assign start_bad   = start_req && !start_legal;
  assign ar_hs       = o_ARVALID && i_ARREADY;
  assign aw_hs       = i_AWVALID && o_AWREADY;
  assign sent_last   = sent_cnt_q == (samp_num_q - 12'd1);
  assign recv_last   = recv_cnt_q == (samp_num_q - 12'd1);
  assign ld_ok       = i_ld_we && !o_busy;
  assign nxt_idx     = sent_cnt_q[DEPTH_W-1:0] + DEPTH_W'(1);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_ok) state_d = S_PREF;
      S_PREF: state_d = S_SEND;
      S_SEND: if (ar_hs && sent_last) state_d = S_RECV;
      S_RECV: if (aw_hs && recv_last) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and status outputs decode straight from state
  always_comb begin
    o_ARVALID = 1'b0;
    o_AWREADY = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_PREF: o_busy = 1'b1;
      S_SEND: begin
        o_busy    = 1'b1;
        o_ARVALID = 1'b1;
      end
      S_RECV: begin
        o_busy    = 1'b1;
        o_AWREADY = 1'b1;
      end
      S_DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    samp_num_d = samp_num_q;
    sent_cnt_d = sent_cnt_q;
    recv_cnt_d = recv_cnt_q;
    error_d    = error_q;
    ardata_d   = ardata_q;
    rd_data_d  = res_mem[i_rd_addr];
    if (start_ok) begin
      samp_num_d = i_samp_number;
      sent_cnt_d = 12'd0;
      recv_cnt_d = 12'd0;
      error_d    = 1'b0;
      ardata_d   = samp_mem[0];
    end
    if (start_bad) error_d = 1'b1;
    // Next word is fetched on the handshake so beats run back-to-back
    if (ar_hs) begin
      sent_cnt_d = sent_cnt_q + 12'd1;
      ardata_d   = samp_mem[nxt_idx];
    end
    if (aw_hs) recv_cnt_d = recv_cnt_q + 12'd1;
`ifdef FFT_HOST_BURST_CHECK_EN
    if (ar_hs && (i_ARBURST != sent_cnt_q[N:0])) error_d = 1'b1;
    if (aw_hs && (i_AWBURST != recv_cnt_q[N:0])) error_d = 1'b1;
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      samp_num_q <= 12'd0;
      sent_cnt_q <= 12'd0;
      recv_cnt_q <= 12'd0;
      error_q    <= 1'b0;
      ardata_q   <= 32'd0;
    end else begin
      samp_num_q <= samp_num_d;
      sent_cnt_q <= sent_cnt_d;
      recv_cnt_q <= recv_cnt_d;
      error_q    <= error_d;
      ardata_q   <= ardata_d;
    end
  end

  // Buffers are not reset; read-during-write returns old data
  always_ff @(posedge i_clk) begin
    if (ld_ok) samp_mem[i_ld_addr] <= i_ld_data;
    if (aw_hs) res_mem[recv_cnt_q[DEPTH_W-1:0]] <= i_AWDATA;
    rd_data_q <= rd_data_d;
  end

  assign o_ARDATA   = ardata_q;
  assign o_rd_data  = rd_data_q;
  assign o_error    = error_q;
  assign o_sent_cnt = sent_cnt_q;
  assign o_recv_cnt = recv_cnt_q;

endmodule
